algo_out_rx_packer: RTL and testbench

- Avalon-ST sink for the 16-bit result stream of algo_top (zero ready latency).
- Packs pairs of 16-bit words into 32-bit beats on an Avalon-ST source toward the DMA/FIFO path.
- Enforces sop/eop framing and flags framing errors.
- Receiver counterpart to the 32-bit packet source that feeds algo_top.

---
 rtl/algo_rx_pkg.sv | 16 +
 rtl/st_out_reg.sv | 46 ++++
 rtl/algo_out_rx_packer.sv | 208 ++++++++++++++++++++
 tb/tb_algo_out_rx_packer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_rx_pkg.sv
// Shared types and constants for the algo_top result-stream receiver/packer.
package algo_rx_pkg;

  localparam int HALF_W = 16;

  localparam logic [1:0] EMPTY_NONE = 2'd0;
  localparam logic [1:0] EMPTY_HALF = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    CLOSE   = 2'd2,
    DISCARD = 2'd3
  } rx_state_e;

endpackage

// File: rtl/st_out_reg.sv
// Single-entry Avalon-ST holding register: 32-bit data plus empty/sop/eop/error.
module st_out_reg
  import algo_rx_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_data,
  input  logic [1:0]            in_empty,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*HALF_W-1:0]   out_data,
  output logic [1:0]            out_empty,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_err
);

  // Room exists when empty or when the held beat leaves this cycle.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_empty <= EMPTY_NONE;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_empty <= in_empty;
      out_sop   <= in_sop;
      out_eop   <= in_eop;
      out_err   <= in_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/algo_out_rx_packer.sv
// Packs 16-bit algo_top result words into 32-bit Avalon-ST beats with framing checks.
// Define ALGO_RX_STATS_EN to build live pkt_count/err_count registers.
// Valid/ready: a beat transfers on a cycle where valid && ready at the rising clk edge.
module algo_out_rx_packer
  import algo_rx_pkg::*;
#(
  parameter int MAX_IN_WORDS = 512,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [HALF_W-1:0]  data_in_data,
  input  logic               data_in_valid,
  output logic               data_in_ready,
  input  logic               data_in_empty,
  input  logic               data_in_startofpacket,
  input  logic               data_in_endofpacket,
  output logic [31:0]        data_out_data,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic [1:0]         data_out_empty,
  output logic               data_out_startofpacket,
  output logic               data_out_endofpacket,
  output logic               data_out_error,
  output logic [CNT_W-1:0]   last_len,
  output logic [CNT_W-1:0]   pkt_count,
  output logic [CNT_W-1:0]   err_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_IN_WORDS);

  rx_state_e         state_q, state_d;
  logic [HALF_W-1:0] hi_q, hi_d;
  logic              pend_q, pend_d;
  logic              first_q, first_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  len_q, len_d;

  logic              st_valid, st_ready, st_push;
  logic [31:0]       st_data;
  logic [1:0]        st_empty;
  logic              st_sop, st_eop, st_err;
  logic              in_acc;

  // A sop arriving mid-packet is refused so the open packet can be closed first.
  assign data_in_ready = st_ready && (state_q != CLOSE) &&
                         !(state_q == IN_PKT && data_in_valid && data_in_startofpacket);
  assign in_acc  = data_in_valid && data_in_ready;
  assign st_push = st_valid && st_ready;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      pend_q  <= pend_d;
      first_q <= first_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    pend_d   = pend_q;
    first_d  = first_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    st_valid = 1'b0;
    st_data  = '0;
    st_empty = EMPTY_NONE;
    st_sop   = 1'b0;
    st_eop   = 1'b0;
    st_err   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_acc && data_in_startofpacket) begin
          if (data_in_endofpacket) begin
            st_valid = 1'b1;
            st_data  = {data_in_data, 16'h0};
            st_empty = EMPTY_HALF + {1'b0, data_in_empty};
            st_sop   = 1'b1;
            st_eop   = 1'b1;
            len_d    = CNT_W'(1);
          end else begin
            hi_d    = data_in_data;
            pend_d  = 1'b1;
            first_d = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = IN_PKT;
          end
        end
      end
      IN_PKT: begin
        if (in_acc) begin
          cnt_d = cnt_inc;
          if (data_in_endofpacket) begin
            st_valid = 1'b1;
            st_data  = pend_q ? {hi_q, data_in_data} : {data_in_data, 16'h0};
            st_empty = (pend_q ? EMPTY_NONE : EMPTY_HALF) + {1'b0, data_in_empty};
            st_sop   = first_q;
            st_eop   = 1'b1;
            len_d    = cnt_inc;
            pend_d   = 1'b0;
            first_d  = 1'b0;
            state_d  = IDLE;
          end else begin
            if (pend_q) begin
              st_valid = 1'b1;
              st_data  = {hi_q, data_in_data};
              st_sop   = first_q;
              first_d  = 1'b0;
              pend_d   = 1'b0;
            end else begin
              hi_d   = data_in_data;
              pend_d = 1'b1;
            end
            if (cnt_inc == MAX_CNT) begin
              ovf_d   = 1'b1;
              state_d = CLOSE;
            end
          end
        end else if (data_in_valid && data_in_startofpacket) begin
          ovf_d   = 1'b0;
          state_d = CLOSE;
        end
      end
      CLOSE: begin
        st_valid = 1'b1;
        st_data  = {(pend_q ? hi_q : 16'h0), 16'h0};
        st_empty = EMPTY_HALF;
        st_sop   = first_q;
        st_eop   = 1'b1;
        st_err   = 1'b1;
        if (st_ready) begin
          len_d   = cnt_q;
          pend_d  = 1'b0;
          first_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ovf_q ? DISCARD : IDLE;
        end
      end
      DISCARD: begin
        if (in_acc && data_in_endofpacket) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  st_out_reg u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (st_valid),
    .in_ready  (st_ready),
    .in_data   (st_data),
    .in_empty  (st_empty),
    .in_sop    (st_sop),
    .in_eop    (st_eop),
    .in_err    (st_err),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready),
    .out_data  (data_out_data),
    .out_empty (data_out_empty),
    .out_sop   (data_out_startofpacket),
    .out_eop   (data_out_endofpacket),
    .out_err   (data_out_error)
  );

  assign last_len = len_q;

`ifdef ALGO_RX_STATS_EN
  logic             pkt_inc, err_inc;
  logic [CNT_W-1:0] pkt_cnt_q, err_cnt_q;

  // Every emitted eop beat closes a packet; close beats also carry the error flag.
  assign pkt_inc = st_push && st_eop;
  assign err_inc = (state_q == IDLE && in_acc && !data_in_startofpacket) || (st_push && st_err);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (pkt_inc && pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      if (err_inc && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign pkt_count = pkt_cnt_q;
  assign err_count = err_cnt_q;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_algo_out_rx_packer.sv
// Directed bench for algo_out_rx_packer (MAX_IN_WORDS=8); stats expectations follow ALGO_RX_STATS_EN.
module tb_algo_out_rx_packer;

`ifdef ALGO_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in_data = '0;
  logic        data_in_valid = 1'b0;
  logic        data_in_ready;
  logic        data_in_empty = 1'b0;
  logic        data_in_startofpacket = 1'b0;
  logic        data_in_endofpacket = 1'b0;
  logic [31:0] data_out_data;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;
  logic [1:0]  data_out_empty;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic        data_out_error;
  logic [15:0] last_len;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  int checks = 0;
  int errors = 0;
  int waited;

  logic [36:0] exp_q[$];
  logic [36:0] obs_q[$];

  algo_out_rx_packer #(.MAX_IN_WORDS(8), .CNT_W(16)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .data_in_data           (data_in_data),
    .data_in_valid          (data_in_valid),
    .data_in_ready          (data_in_ready),
    .data_in_empty          (data_in_empty),
    .data_in_startofpacket  (data_in_startofpacket),
    .data_in_endofpacket    (data_in_endofpacket),
    .data_out_data          (data_out_data),
    .data_out_valid         (data_out_valid),
    .data_out_ready         (data_out_ready),
    .data_out_empty         (data_out_empty),
    .data_out_startofpacket (data_out_startofpacket),
    .data_out_endofpacket   (data_out_endofpacket),
    .data_out_error         (data_out_error),
    .last_len               (last_len),
    .pkt_count              (pkt_count),
    .err_count              (err_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [36:0] beat(input logic [31:0] d, input logic [1:0] e,
                                       input logic s, input logic eo, input logic er);
    return {d, e, s, eo, er};
  endfunction

  // driver: called at posedge+1, returns at posedge+1 after the beat is accepted
  task automatic send(input logic [15:0] d, input logic s, input logic e, input logic em,
                      output int w);
    bit done;
    data_in_data          = d;
    data_in_startofpacket = s;
    data_in_endofpacket   = e;
    data_in_empty         = em;
    data_in_valid         = 1'b1;
    w    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (data_in_ready) done = 1'b1;
      else begin
        w++;
        if (w > 200) begin
          chk("send_timeout", 64'(w), 64'd0);
          done = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    data_in_valid         = 1'b0;
    data_in_startofpacket = 1'b0;
    data_in_endofpacket   = 1'b0;
    data_in_empty         = 1'b0;
  endtask

  // monitor: a beat seen with valid && ready at negedge transfers on the next edge
  always @(negedge clk) begin
    if (!rst && data_out_valid && data_out_ready)
      obs_q.push_back({data_out_data, data_out_empty, data_out_startofpacket,
                       data_out_endofpacket, data_out_error});
  end

  // scoreboard
  task automatic check_beats(input string tag);
    int n;
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cnt_bad;
    int vw;

    do_reset();
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", 64'(data_out_data), 64'd0);
    chk("rst_sop_eop_err", 64'({data_out_startofpacket, data_out_endofpacket, data_out_error}), 64'd0);
    chk("rst_last_len", 64'(last_len), 64'd0);
    chk("rst_pkt_count", 64'(pkt_count), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_ready", 64'(data_in_ready), 64'd1);

    // basic even-length packing
    exp_q.push_back(beat(32'h0001_0002, 2'd0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h0003_0004, 2'd0, 1'b0, 1'b1, 1'b0));
    send(16'h0001, 1'b1, 1'b0, 1'b0, waited);
    send(16'h0002, 1'b0, 1'b0, 1'b0, waited);
    send(16'h0003, 1'b0, 1'b0, 1'b0, waited);
    send(16'h0004, 1'b0, 1'b1, 1'b0, waited);
    check_beats("basic");
    chk("basic_last_len", 64'(last_len), 64'd4);
    chk("basic_pkt_count", 64'(pkt_count), STATS ? 64'd1 : 64'd0);

    // odd length, then a single-word packet with a byte of empty
    exp_q.push_back(beat(32'h000A_000B, 2'd0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h000C_0000, 2'd2, 1'b0, 1'b1, 1'b0));
    send(16'h000A, 1'b1, 1'b0, 1'b0, waited);
    send(16'h000B, 1'b0, 1'b0, 1'b0, waited);
    send(16'h000C, 1'b0, 1'b1, 1'b0, waited);
    check_beats("odd");
    chk("odd_last_len", 64'(last_len), 64'd3);
    exp_q.push_back(beat(32'h1234_0000, 2'd3, 1'b1, 1'b1, 1'b0));
    send(16'h1234, 1'b1, 1'b1, 1'b1, waited);
    check_beats("single");
    chk("single_last_len", 64'(last_len), 64'd1);
    chk("single_pkt_count", 64'(pkt_count), STATS ? 64'd3 : 64'd0);

    // backpressure: output stalled for 5 cycles once the first beat is held
    exp_q.push_back(beat(32'h0011_0022, 2'd0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h0033_0044, 2'd0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h0055_0066, 2'd0, 1'b0, 1'b1, 1'b0));
    data_out_ready = 1'b0;
    fork
      begin
        send(16'h0011, 1'b1, 1'b0, 1'b0, waited);
        send(16'h0022, 1'b0, 1'b0, 1'b0, waited);
        send(16'h0033, 1'b0, 1'b0, 1'b0, waited);
        send(16'h0044, 1'b0, 1'b0, 1'b0, waited);
        send(16'h0055, 1'b0, 1'b0, 1'b0, waited);
        send(16'h0066, 1'b0, 1'b1, 1'b0, waited);
      end
      begin
        vw = 0;
        while (!data_out_valid && vw < 50) begin
          @(negedge clk);
          vw++;
        end
        chk("stall_valid_seen", 64'(data_out_valid), 64'd1);
        cnt_bad = 0;
        repeat (5) begin
          @(negedge clk);
          if (data_in_ready !== 1'b0 || data_out_valid !== 1'b1 ||
              data_out_data !== 32'h0011_0022 || data_out_startofpacket !== 1'b1)
            cnt_bad++;
        end
        chk("stall_hold", 64'(cnt_bad), 64'd0);
        chk("stall_data", 64'(data_out_data), 64'h0011_0022);
        chk("stall_in_ready", 64'(data_in_ready), 64'd0);
        @(posedge clk); #1;
        data_out_ready = 1'b1;
      end
    join
    check_beats("bp");
    chk("bp_last_len", 64'(last_len), 64'd6);

    // missing sop while idle
    do_reset();
    send(16'h0077, 1'b0, 1'b0, 1'b0, waited);
    chk("nosop_wait1", 64'(waited), 64'd0);
    send(16'h0088, 1'b0, 1'b1, 1'b0, waited);
    chk("nosop_wait2", 64'(waited), 64'd0);
    chk("nosop_ready", 64'(data_in_ready), 64'd1);
    check_beats("nosop");
    chk("nosop_err_count", 64'(err_count), STATS ? 64'd2 : 64'd0);
    chk("nosop_pkt_count", 64'(pkt_count), 64'd0);

    // restart: sop arrives with a half word pending
    do_reset();
    exp_q.push_back(beat(32'h00A1_00A2, 2'd0, 1'b1, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h00A3_0000, 2'd2, 1'b0, 1'b1, 1'b1));
    exp_q.push_back(beat(32'h00B1_00B2, 2'd0, 1'b1, 1'b1, 1'b0));
    send(16'h00A1, 1'b1, 1'b0, 1'b0, waited);
    send(16'h00A2, 1'b0, 1'b0, 1'b0, waited);
    send(16'h00A3, 1'b0, 1'b0, 1'b0, waited);
    send(16'h00B1, 1'b1, 1'b0, 1'b0, waited);
    chk("restart_refused", 64'(waited != 0), 64'd1);
    chk("restart_close_len", 64'(last_len), 64'd3);
    send(16'h00B2, 1'b0, 1'b1, 1'b0, waited);
    check_beats("restart");
    chk("restart_last_len", 64'(last_len), 64'd2);
    chk("restart_err_count", 64'(err_count), STATS ? 64'd1 : 64'd0);
    chk("restart_pkt_count", 64'(pkt_count), STATS ? 64'd2 : 64'd0);

    // mid-packet reset drops the open packet silently
    exp_q.push_back(beat(32'h0005_0006, 2'd0, 1'b1, 1'b0, 1'b0));
    send(16'h0005, 1'b1, 1'b0, 1'b0, waited);
    send(16'h0006, 1'b0, 1'b0, 1'b0, waited);
    send(16'h0007, 1'b0, 1'b0, 1'b0, waited);
    repeat (2) @(posedge clk);
    do_reset();
    check_beats("midrst");
    chk("midrst_valid", 64'(data_out_valid), 64'd0);
    chk("midrst_last_len", 64'(last_len), 64'd0);

    // overflow: 12 words against a limit of 8
    for (int i = 1; i <= 4; i++)
      exp_q.push_back(beat({16'(2*i-1), 16'(2*i)}, 2'd0, i == 1, 1'b0, 1'b0));
    exp_q.push_back(beat(32'h0000_0000, 2'd2, 1'b0, 1'b1, 1'b1));
    for (int i = 1; i <= 12; i++)
      send(16'(i), i == 1, i == 12, 1'b0, waited);
    check_beats("ovf");
    chk("ovf_last_len", 64'(last_len), 64'd8);
    chk("ovf_err_count", 64'(err_count), STATS ? 64'd1 : 64'd0);
    chk("ovf_pkt_count", 64'(pkt_count), STATS ? 64'd1 : 64'd0);
    exp_q.push_back(beat(32'h0021_0022, 2'd0, 1'b1, 1'b1, 1'b0));
    send(16'h0021, 1'b1, 1'b0, 1'b0, waited);
    send(16'h0022, 1'b0, 1'b1, 1'b0, waited);
    check_beats("post_ovf");
    chk("post_ovf_last_len", 64'(last_len), 64'd2);
    chk("post_ovf_pkt_count", 64'(pkt_count), STATS ? 64'd2 : 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
